pipelined_fastadder: RTL

- Streaming, pipelined m-operand two's-complement adder. It sums M operands of N bits each, with a per-operand negate mask, a signed/unsigned mode and a carry-in.
- Operands are reduced with a linear chain of 3:2 carry-save adders. A register stage follows every PIPE CSA levels, and a registered final carry-propagate adder closes the pipeline.
- Valid/ready handshakes on input and output, with full backpressure and bubble collapsing.
- Sits in the datapath wherever several wide operands must be summed at full clock rate.

---
 rtl/pipelined_fastadder.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipelined_fastadder.sv
// Streaming M-operand adder: a linear 3:2 carry-save chain, registered every PIPE levels,
// then a registered carry-propagate adder. Valid/ready on both sides with bubble collapsing.
module pipelined_fastadder #(
   parameter int M    = 5,
   parameter int N    = 64,
   parameter int PIPE = 1,
   parameter int G    = $clog2(M) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [M*N-1:0]   x,
   input  logic [M-1:0]     neg,
   input  logic             is_signed,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N+G-1:0]   S
);

   localparam int W  = N + G;
   localparam int R  = M - 1;
   localparam int NS = (R + PIPE - 1) / PIPE;
   localparam int L  = NS + 1;

   typedef logic [M:0][W-1:0] rows_t;

   rows_t          rows0;
   rows_t          cur;
   rows_t          d [NS];
   rows_t          q [NS];
   logic [W-1:0]   ca, cb, cc;
   logic [N-1:0]   op;
   logic [W-1:0]   ext;
   logic [W-1:0]   corr;
   logic [L-1:0]   v, v_nxt, adv, load;
   logic           go;

   // Inverting a negated operand leaves a -1 per row; the correction row adds those back with cin.
   always_comb begin
      rows0 = '0;
      op    = '0;
      ext   = '0;
      corr  = W'(cin);
      for (int i = 0; i < M; i++) begin
         op       = x[i*N +: N];
         ext      = is_signed ? {{G{op[N-1]}}, op} : {{G{1'b0}}, op};
         rows0[i] = neg[i] ? ~ext : ext;
         corr     = corr + W'(neg[i]);
      end
      rows0[M] = corr;
   end

   // Level j folds rows j-1..j+1 in place: carry lands in row j, sum in row j+1.
   always_comb begin
      cur = rows0;
      ca  = '0;
      cb  = '0;
      cc  = '0;
      for (int s = 0; s < NS; s++) begin
         for (int j = 1; j <= R; j++) begin
            if (j > s*PIPE && j <= (s+1)*PIPE) begin
               ca       = cur[j-1];
               cb       = cur[j];
               cc       = cur[j+1];
               cur[j]   = ((ca & cb) | (ca & cc) | (cb & cc)) << 1;
               cur[j+1] = ca ^ cb ^ cc;
            end
         end
         d[s] = cur;
         cur  = q[s];
      end
   end

   // Advance chain runs from the output back to the input; a stage may move if the next one is free or moving.
   always_comb begin
      adv = '0;
      go  = out_ready;
      for (int k = L-1; k >= 0; k--) begin
         adv[k] = v[k] & go;
         go     = ~v[k] | adv[k];
      end
      in_ready = go;
      load     = {adv[L-2:0], in_valid & go};
      v_nxt    = load | (v & ~adv);
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < NS; s++) begin
         if (load[s]) q[s] <= d[s];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v <= '0;
         S <= '0;
      end else begin
         v <= v_nxt;
         if (load[L-1]) S <= q[NS-1][M-1] + q[NS-1][M];
      end
   end

   assign out_valid = v[L-1];

endmodule
